// File: rtl/tdm_pkg.sv
// Shared definitions for the 1-bit TDM link (transmitter and receiver).
//   tdm_state_t : receiver framing states (IDLE waits for slot 0, COLLECT fills slots)
//   slot_width  : width of a slot index for an n-slot frame
package tdm_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } tdm_state_t;

  // Slot index width for an n-slot frame. Both ends of the link must agree on
  // this, so it lives here rather than in either module. n < 2 is not a legal
  // frame size; it still yields a 1-bit index so nothing collapses to zero width.
  function automatic int slot_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_1bit_mod_n_counter.sv
// Modulo-n counter used as the TDM slot index (and as the mux select on the
// transmit side).
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; count returns to 0
//   clr_in    : restart the count at slot 0
//   en_in     : advance the count by one slot (wraps n-1 -> 0)
//   count_out : current slot index, 0..n-1
//   last_out  : count_out == n-1
// clr_in and en_in together mean "this cycle is slot 0 and it is consumed",
// so the count lands on 1. That lets a frame start be a single-cycle event.
module mod_n_counter
  import tdm_pkg::*;
#(
  parameter int n = 4,
  localparam int W = slot_width(n)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_in,
  input  logic         en_in,
  output logic [W-1:0] count_out,
  output logic         last_out
);

  localparam logic [W-1:0] LAST = W'(n - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr_in) begin
      count <= en_in ? ONE : '0;
    end else if (en_in) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

  assign count_out = count;
  assign last_out  = (count == LAST);

endmodule

// File: rtl/tdm_demux_1bit.sv
// Receive end of the 1-bit TDM link: steers each serial bit back to its slot
// and presents the rebuilt word once all slots of a frame have arrived.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; discards any partial frame, q_out -> 0
//   d_in      : serial data bit for the current slot
//   en_in     : d_in is valid this cycle (bits are consumed only when high)
//   sync_in   : the bit on d_in is slot 0 of a frame (qualified by en_in)
//   s_out     : slot index the next consumed bit will be written to
//   q_out     : last complete frame, bit k = bit received in slot k
//   valid_out : one-cycle pulse, q_out updated this cycle
//   err_out   : one-cycle pulse, sync seen mid-frame (partial frame dropped)
// Legal for outputs >= 2; outputs need not be a power of two.
module tdm_demux_1bit
  import tdm_pkg::*;
#(
  parameter int outputs = 4,
  localparam int SLOT_W = slot_width(outputs)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_in,
  input  logic               en_in,
  input  logic               sync_in,
  output logic [SLOT_W-1:0]  s_out,
  output logic [outputs-1:0] q_out,
  output logic               valid_out,
  output logic               err_out
);

  tdm_state_t         state, state_next;
  logic [outputs-1:0] hold, hold_next;
  logic [outputs-1:0] q_next;
  logic               valid_next, err_next;
  logic               cnt_clr, cnt_en;
  logic               slot_last;

  // Slot index. It only reaches 0 again through frame completion, a restart,
  // or reset, so in IDLE it always reads 0.
  mod_n_counter #(
    .n (outputs)
  ) u_slot_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr_in    (cnt_clr),
    .en_in     (cnt_en),
    .count_out (s_out),
    .last_out  (slot_last)
  );

  // Next-state / datapath decode.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    q_next     = q_out;
    valid_next = 1'b0;
    err_next   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Non-sync bits while idle are line noise before the first frame
        // start; they are dropped silently.
        if (en_in && sync_in) begin
          hold_next    = '0;
          hold_next[0] = d_in;
          cnt_clr      = 1'b1;
          cnt_en       = 1'b1;
          state_next   = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (en_in) begin
          if (sync_in) begin
            // In COLLECT the slot index is never 0, so a sync here always
            // lands mid-frame: flag it and restart with this bit as slot 0.
            // Clearing the holding word keeps stale bits out of the next frame.
            err_next     = 1'b1;
            hold_next    = '0;
            hold_next[0] = d_in;
            cnt_clr      = 1'b1;
            cnt_en       = 1'b1;
          end else begin
            hold_next[s_out] = d_in;
            cnt_en           = 1'b1;
            if (slot_last) begin
              // Publish the word including the bit arriving right now, so the
              // frame is visible on the edge that samples its last slot.
              q_next     = hold_next;
              valid_next = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  // NOTE: the holding word is a handful of flops, not a memory, so it is reset
  // along with everything else; a discarded frame can never leak into q_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold      <= '0;
      q_out     <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      q_out     <= q_next;
      valid_out <= valid_next;
      err_out   <= err_next;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1bit.sv
// Self-checking bench for tdm_demux_1bit with outputs = 4.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 time unit after the edge that consumed the inputs.
module tb_tdm_demux_1bit;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_in;
  logic          en_in;
  logic          sync_in;
  logic [SW-1:0] s_out;
  logic [N-1:0]  q_out;
  logic          valid_out;
  logic          err_out;

  tdm_demux_1bit #(
    .outputs (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .en_in     (en_in),
    .sync_in   (sync_in),
    .s_out     (s_out),
    .q_out     (q_out),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of received bits. A sync starts a new
  // list (an error if one was already open); N bits close it into a word.
  bit           m_frame[$];
  bit           m_open  = 1'b0;
  logic [N-1:0] m_q     = '0;
  bit           m_valid = 1'b0;
  bit           m_err   = 1'b0;

  task automatic model_step(input bit r, input bit d, input bit en, input bit sy);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_frame.delete();
      m_open = 1'b0;
      m_q    = '0;
    end else if (en) begin
      if (sy) begin
        if (m_open) m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
        m_open = 1'b1;
      end else if (m_open) begin
        m_frame.push_back(d);
        if (m_frame.size() == N) begin
          for (int k = 0; k < N; k++) m_q[k] = m_frame[k];
          m_valid = 1'b1;
          m_frame.delete();
          m_open = 1'b0;
        end
      end
    end
  endtask

  // Apply one cycle of inputs and compare every output against the model.
  task automatic step(input bit r, input bit d, input bit en, input bit sy, input string tag);
    int m_slot;
    reset   = r;
    d_in    = d;
    en_in   = en;
    sync_in = sy;
    model_step(r, d, en, sy);
    m_slot = m_open ? m_frame.size() : 0;
    @(posedge clk);
    #1;
    check({tag, " q_out"},     32'(q_out),     32'(m_q));
    check({tag, " s_out"},     32'(s_out),     32'(m_slot));
    check({tag, " valid_out"}, 32'(valid_out), 32'(m_valid));
    check({tag, " err_out"},   32'(err_out),   32'(m_err));
  endtask

  typedef struct {
    bit            r, d, en, sy;
    logic [N-1:0]  q;
    logic [SW-1:0] s;
    bit            v, e;
  } vec_t;

  vec_t tbl[$];

  initial begin : main
    int            vcyc[$];
    int            cyc;
    int            idx;
    bit            b2b[8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    bit            r, en, sy;

    reset = 1'b1; d_in = 1'b0; en_in = 1'b0; sync_in = 1'b0;

    // ---- table-driven vectors: {r, d, en, sy, q, s, v, e} ----
    // reset held with d_in/en_in toggling
    tbl.push_back('{1, 1, 1, 0, 4'b0000, 2'd0, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 4'b0000, 2'd0, 0, 0});
    // frame 0,1,1,1 back to back
    tbl.push_back('{0, 0, 1, 1, 4'b0000, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 4'b0000, 2'd2, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 4'b0000, 2'd3, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 4'b1110, 2'd0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 4'b1110, 2'd0, 0, 0});
    // frame 1,0,0,0 with 3-cycle gaps
    tbl.push_back('{0, 1, 1, 1, 4'b1110, 2'd1, 0, 0});
    for (int g = 0; g < 3; g++) tbl.push_back('{0, 1, 0, 0, 4'b1110, 2'd1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'b1110, 2'd2, 0, 0});
    for (int g = 0; g < 3; g++) tbl.push_back('{0, 1, 0, 1, 4'b1110, 2'd2, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'b1110, 2'd3, 0, 0});
    for (int g = 0; g < 3; g++) tbl.push_back('{0, 0, 0, 0, 4'b1110, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'b0001, 2'd0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 4'b0001, 2'd0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].en, tbl[i].sy, $sformatf("tbl[%0d]", i));
      check($sformatf("tbl[%0d] exp q", i), 32'(q_out),     32'(tbl[i].q));
      check($sformatf("tbl[%0d] exp s", i), 32'(s_out),     32'(tbl[i].s));
      check($sformatf("tbl[%0d] exp v", i), 32'(valid_out), 32'(tbl[i].v));
      check($sformatf("tbl[%0d] exp e", i), 32'(err_out),   32'(tbl[i].e));
    end

    // ---- sync mid-frame: 1,1 then sync at slot 2 with 0, then 1,0,1 ----
    step(0, 1, 1, 1, "err0");
    step(0, 1, 1, 0, "err1");
    step(0, 0, 1, 1, "err2");
    check("err pulse", 32'(err_out), 32'd1);
    check("err restart slot", 32'(s_out), 32'd1);
    check("err q held", 32'(q_out), 32'b0001);
    step(0, 1, 1, 0, "err3");
    check("err no repeat", 32'(err_out), 32'd0);
    step(0, 0, 1, 0, "err4");
    step(0, 1, 1, 0, "err5");
    check("err frame q", 32'(q_out), 32'b1010);
    check("err frame valid", 32'(valid_out), 32'd1);
    check("err frame no err", 32'(err_out), 32'd0);

    // ---- non-sync bits in IDLE are ignored ----
    for (int i = 0; i < 6; i++) begin
      step(0, i[0], 1, 0, "idle");
      check("idle valid", 32'(valid_out), 32'd0);
      check("idle err",   32'(err_out),   32'd0);
      check("idle slot",  32'(s_out),     32'd0);
    end

    // ---- reset after two bits of a frame ----
    step(0, 1, 1, 1, "rst0");
    step(0, 1, 1, 0, "rst1");
    step(1, 1, 1, 0, "rst2");
    check("rst q cleared", 32'(q_out), 32'd0);
    check("rst slot", 32'(s_out), 32'd0);
    step(0, 1, 1, 0, "rst3");  // back in IDLE: a non-sync bit goes nowhere
    check("rst idle slot", 32'(s_out), 32'd0);

    // ---- back-to-back frames 1,0,0,0 then 0,1,1,1 ----
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, b2b[i], 1, (i % 4) == 0, "b2b");
      cyc++;
      if (valid_out) vcyc.push_back(cyc);
      if (i == 3) check("b2b q first", 32'(q_out), 32'b0001);
      if (i == 7) check("b2b q second", 32'(q_out), 32'b1110);
    end
    check("b2b valid count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) check("b2b valid spacing", 32'(vcyc[1] - vcyc[0]), 32'd4);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      idx = int'($urandom_range(0, 99));
      r   = (idx < 2);
      en  = ($urandom_range(0, 9) < 7);
      sy  = ($urandom_range(0, 5) == 0);
      step(r, 1'($urandom), en, sy, "rand");
      check("rand exclusive", 32'(valid_out & err_out), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
